s_core_boot_loader: RTL and testbench
=====================================

// Module: s_core_boot_loader
// PURPOSE
//  Upstream of s_core_pipelined. Consumes a valid/ready stream of load records and
//  writes the core's instruction memory and register file while holding the core in
//  reset. It then releases the core at a programmed start PC.
//  Replaces hand-sequenced setup/inst_mem/load_reg stimulus with a reusable FSM.
// PARAMETERS
//  IMEM_DEPTH_WORDS  1024  instruction memory size in 32-bit words; bounds INSTR addresses
//  RELEASE_CYCLES    2     cycles o_core_rst_n stays low after END is accepted (>=1)
// PORTS
//  clk                    in   1   clock, all state on rising edge
//  rst                    in   1   reset, asynchronous, active-high
//  i_start                in   1   begin/restart a load session (1-cycle pulse)
//  i_rec_valid            in   1   record valid
//  o_rec_ready            out  1   record ready
//  i_rec_type             in   2   00 INSTR, 01 REG, 10 START_PC, 11 END
//  i_rec_addr             in   32  byte addr (INSTR); reg index in [4:0] (REG)
//  i_rec_data             in   32  instr word / reg value / start PC / checksum (END)
//  o_setup                out  1   core setup mode
//  o_inst_mem_we          out  1   imem write strobe
//  o_inst_mem_addr        out  32  imem byte address
//  o_inst_mem_data        out  32  imem write data
//  o_load_reg_we          out  1   regfile write strobe
//  o_load_reg_addr        out  5   regfile index
//  o_load_reg_data        out  32  regfile write data
//  o_pc_instr_start_addr  out  32  core start PC
//  o_core_rst_n           out  1   core reset, active-low
//  o_busy                 out  1   LOAD or RELEASE state
//  o_done                 out  1   core running
//  o_err                  out  1   sticky error
//  o_err_code             out  2   01 bad INSTR addr, 10 checksum mismatch
//  o_instr_count          out  16  INSTR records written, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state IDLE.
//   - All outputs 0, except o_setup=1 and o_core_rst_n=0.
//   - o_pc_instr_start_addr=0.
//  FSM IDLE->LOAD->RELEASE->RUN; ERR from LOAD.
//  IDLE:
//   - o_rec_ready=0.
//   - i_start -> LOAD; clears o_instr_count, start PC, checksum.
//  LOAD:
//   - o_rec_ready=1, o_busy=1; accept on i_rec_valid & o_rec_ready.
//   - Write strobes are registered: one-cycle pulse in the cycle after acceptance.
//     One record per cycle, back-to-back accepted.
//   - INSTR: check i_rec_addr[1:0]==0 and i_rec_addr < IMEM_DEPTH_WORDS*4.
//     Pass: drive imem addr/data with we=1; o_instr_count+1.
//     Fail: no write, -> ERR, code 01.
//   - REG: index = i_rec_addr[4:0].
//     Index 0: record silently dropped; no we, no error.
//     Otherwise: regfile write.
//   - START_PC: latch i_rec_data[31:2],2'b00. Last one wins; default 0 if none received.
//   - END: -> RELEASE, o_rec_ready=0 from the next cycle.
//   - i_start ignored in LOAD.
//  RELEASE:
//   - o_setup=1, o_core_rst_n=0 for exactly RELEASE_CYCLES cycles, then RUN.
//  RUN:
//   - o_setup=0, o_core_rst_n=1, o_done=1, o_busy=0.
//   - i_start -> LOAD; the same edge drives o_core_rst_n=0, o_setup=1, o_done=0 and
//     clears counters.
//  ERR:
//   - o_err=1 and o_err_code hold; o_rec_ready=0.
//   - Core stays in reset with o_setup=1.
//   - i_start -> LOAD and clears o_err / o_err_code.
//  rst asserted mid-LOAD: in-flight strobe dropped, returns to IDLE; partial imem
//   contents are not scrubbed.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined:
//   - Running XOR of i_rec_data over accepted INSTR records.
//   - END compares it against i_rec_data.
//     Mismatch -> ERR, code 10, no release. Match -> RELEASE.
//  BOOT_CHECKSUM_EN undefined:
//   - END i_rec_data ignored, no checksum logic, code 10 never produced.
// TESTING
//  1 Reset, i_start; INSTR@0x4 0x00127413, INSTR@0x8 0x006201B3; REG x4=0x1;
//    START_PC 0x4; END -> two imem strobes one cycle after each accept;
//    o_instr_count=2, o_pc_instr_start_addr=0x4.
//    o_core_rst_n low exactly RELEASE_CYCLES after END, then o_done=1, o_setup=0.
//  2 INSTR@0x6 -> no imem write, o_err=1, code 01, o_core_rst_n=0.
//    i_start clears the error and returns to LOAD.
//  3 INSTR@IMEM_DEPTH_WORDS*4 -> code 01.
//    REG x0=0xFFFF -> no o_load_reg_we and no error.
//  4 i_rec_valid held high for 5 back-to-back INSTR records -> 5 consecutive we
//    pulses, correct addr/data order.
//    Deassert valid mid-stream -> no strobe in the gap cycle.
//  5 In RUN, pulse i_start -> o_core_rst_n=0 and o_done=0 on the same edge.
//    Assert rst mid-LOAD -> IDLE, outputs at reset values asynchronously.
//  6 BOOT_CHECKSUM_EN: records 0x1,0x2,0x4, END data 0x7 -> RUN; END data 0x6 -> ERR,
//    code 10. Without the macro, END 0x6 -> RUN.

Source files
------------

// File: rtl/s_core_boot_loader.sv
// Boot loader for s_core_pipelined: streams INSTR/REG/START_PC/END records into imem and regfile, then releases the core.
// Optional END checksum over INSTR data is enabled by defining BOOT_CHECKSUM_EN.
module s_core_boot_loader #(
    parameter int unsigned IMEM_DEPTH_WORDS = 1024,
    parameter int unsigned RELEASE_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_rec_valid,
    output logic        o_rec_ready,
    input  logic [1:0]  i_rec_type,
    input  logic [31:0] i_rec_addr,
    input  logic [31:0] i_rec_data,
    output logic        o_setup,
    output logic        o_inst_mem_we,
    output logic [31:0] o_inst_mem_addr,
    output logic [31:0] o_inst_mem_data,
    output logic        o_load_reg_we,
    output logic [4:0]  o_load_reg_addr,
    output logic [31:0] o_load_reg_data,
    output logic [31:0] o_pc_instr_start_addr,
    output logic        o_core_rst_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_ERR
    } state_e;

    localparam logic [1:0]  REC_INSTR = 2'b00;
    localparam logic [1:0]  REC_REG   = 2'b01;
    localparam logic [1:0]  REC_PC    = 2'b10;
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_DEPTH_WORDS) << 2;
    localparam int unsigned RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RELEASE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [RC_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic              im_we_q, im_we_d;
    logic [31:0]       im_addr_q, im_addr_d;
    logic [31:0]       im_data_q, im_data_d;
    logic              rg_we_q, rg_we_d;
    logic [4:0]        rg_addr_q, rg_addr_d;
    logic [31:0]       rg_data_q, rg_data_d;
    logic [31:0]       pc_q, pc_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [15:0]       cnt_q, cnt_d;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic accept;
    logic instr_ok;

    assign accept   = i_rec_valid && (state_q == S_LOAD);
    assign instr_ok = (i_rec_addr[1:0] == 2'b00) && ({1'b0, i_rec_addr} < IMEM_BYTES);

    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        im_we_d   = 1'b0;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;
        rg_we_d   = 1'b0;
        rg_addr_d = rg_addr_q;
        rg_data_d = rg_data_q;
        pc_d      = pc_q;
        err_d     = err_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    code_d  = '0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    case (i_rec_type)
                        REC_INSTR: begin
                            if (instr_ok) begin
                                im_we_d   = 1'b1;
                                im_addr_d = i_rec_addr;
                                im_data_d = i_rec_data;
                                if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
`ifdef BOOT_CHECKSUM_EN
                                csum_d    = csum_q ^ i_rec_data;
`endif
                            end else begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                                code_d  = 2'b01;
                            end
                        end
                        REC_REG: begin
                            // x0 is hardwired in the core, so writes to it are dropped
                            if (i_rec_addr[4:0] != 5'd0) begin
                                rg_we_d   = 1'b1;
                                rg_addr_d = i_rec_addr[4:0];
                                rg_data_d = i_rec_data;
                            end
                        end
                        REC_PC: pc_d = {i_rec_data[31:2], 2'b00};
                        default: begin
                            rel_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
                            if (csum_q != i_rec_data) begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                                code_d  = 2'b10;
                            end else begin
                                state_d = S_RELEASE;
                            end
`else
                            state_d = S_RELEASE;
`endif
                        end
                    endcase
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == RC_LAST) state_d = S_RUN;
                else rel_cnt_d = rel_cnt_q + RC_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rel_cnt_q <= '0;
            im_we_q   <= 1'b0;
            im_addr_q <= '0;
            im_data_q <= '0;
            rg_we_q   <= 1'b0;
            rg_addr_q <= '0;
            rg_data_q <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            code_q    <= '0;
            cnt_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
            im_we_q   <= im_we_d;
            im_addr_q <= im_addr_d;
            im_data_q <= im_data_d;
            rg_we_q   <= rg_we_d;
            rg_addr_q <= rg_addr_d;
            rg_data_q <= rg_data_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Core control decodes straight from the state register so it follows the same edge
    assign o_rec_ready           = (state_q == S_LOAD);
    assign o_busy                = (state_q == S_LOAD) || (state_q == S_RELEASE);
    assign o_done                = (state_q == S_RUN);
    assign o_core_rst_n          = (state_q == S_RUN);
    assign o_setup               = (state_q != S_RUN);
    assign o_inst_mem_we         = im_we_q;
    assign o_inst_mem_addr       = im_addr_q;
    assign o_inst_mem_data       = im_data_q;
    assign o_load_reg_we         = rg_we_q;
    assign o_load_reg_addr       = rg_addr_q;
    assign o_load_reg_data       = rg_data_q;
    assign o_pc_instr_start_addr = pc_q;
    assign o_err                 = err_q;
    assign o_err_code            = code_q;
    assign o_instr_count         = cnt_q;

endmodule

// File: tb/tb_s_core_boot_loader.sv
// Self-checking bench for s_core_boot_loader: single-record vector table, directed boot sequences,
// and random record sessions checked against a transaction-level model.
module tb_s_core_boot_loader;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned REL   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_rec_valid = 1'b0;
    logic        o_rec_ready;
    logic [1:0]  i_rec_type = 2'b00;
    logic [31:0] i_rec_addr = '0;
    logic [31:0] i_rec_data = '0;
    logic        o_setup, o_inst_mem_we, o_load_reg_we, o_core_rst_n, o_busy, o_done, o_err;
    logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_instr_start_addr;
    logic [4:0]  o_load_reg_addr;
    logic [1:0]  o_err_code;
    logic [15:0] o_instr_count;

    s_core_boot_loader #(.IMEM_DEPTH_WORDS(DEPTH), .RELEASE_CYCLES(REL)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_rec_valid(i_rec_valid), .o_rec_ready(o_rec_ready), .i_rec_type(i_rec_type),
        .i_rec_addr(i_rec_addr), .i_rec_data(i_rec_data), .o_setup(o_setup),
        .o_inst_mem_we(o_inst_mem_we), .o_inst_mem_addr(o_inst_mem_addr),
        .o_inst_mem_data(o_inst_mem_data), .o_load_reg_we(o_load_reg_we),
        .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data),
        .o_pc_instr_start_addr(o_pc_instr_start_addr), .o_core_rst_n(o_core_rst_n),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
        .o_instr_count(o_instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        im_we;
        logic        rg_we;
        logic [1:0]  code;
        logic [31:0] pc;
        logic [15:0] cnt;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned orphans = 0;
    rec_t        sess_q[$];
    logic [63:0] obs_im[$], obs_rg[$], exp_im[$], exp_rg[$];
    logic        pa_im = 1'b0, pa_rg = 1'b0;
    vec_t        vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write strobes must appear only in the cycle right after an accepted INSTR/REG record
    always @(negedge clk) begin
        if (rst) begin
            pa_im = 1'b0;
            pa_rg = 1'b0;
        end else begin
            if (o_inst_mem_we) begin
                obs_im.push_back({o_inst_mem_addr, o_inst_mem_data});
                if (!pa_im) orphans++;
            end
            if (o_load_reg_we) begin
                obs_rg.push_back({27'b0, o_load_reg_addr, o_load_reg_data});
                if (!pa_rg) orphans++;
            end
            pa_im = i_rec_valid && o_rec_ready && (i_rec_type == 2'b00);
            pa_rg = i_rec_valid && o_rec_ready && (i_rec_type == 2'b01);
        end
    end

    task automatic start_session();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("load_entry_ready", 32'(o_rec_ready), 32'd1);
    endtask

    task automatic send(input rec_t r);
        i_rec_valid = 1'b1;
        i_rec_type  = r.typ;
        i_rec_addr  = r.addr;
        i_rec_data  = r.data;
        @(posedge clk); #1;
        i_rec_valid = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (o_busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic finish_session();
        rec_t r;
        r.typ = 2'b11; r.addr = '0; r.data = '0;
        send(r);
        wait_not_busy();
    endtask

    // Transaction-level model: walk the record list, decide the write lists and the final outcome
    task automatic play_session(input int unsigned gap_pct);
        logic [15:0] m_cnt = '0;
        logic [31:0] m_pc = '0, m_csum = '0;
        logic [1:0]  m_code = '0;
        logic        stop = 1'b0;
        int          n_send = 0;
        int          low = 0;
        rec_t        r;
        obs_im.delete(); obs_rg.delete(); exp_im.delete(); exp_rg.delete();
        for (int i = 0; i < sess_q.size() && !stop; i++) begin
            r = sess_q[i];
            n_send++;
            if (r.typ == 2'b00) begin
                if (r.addr % 4 != 0 || r.addr >= 32'(DEPTH * 4)) begin
                    m_code = 2'b01; stop = 1'b1;
                end else begin
                    exp_im.push_back({r.addr, r.data});
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    m_csum ^= r.data;
                end
            end else if (r.typ == 2'b01) begin
                if (r.addr[4:0] != 5'd0) exp_rg.push_back({27'b0, r.addr[4:0], r.data});
            end else if (r.typ == 2'b10) begin
                m_pc = r.data & 32'hFFFF_FFFC;
            end else begin
`ifdef BOOT_CHECKSUM_EN
                if (m_csum != r.data) m_code = 2'b10;
`endif
                stop = 1'b1;
            end
        end
        start_session();
        for (int i = 0; i < n_send; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                i_rec_valid = 1'b0;
                i_rec_type  = 2'($urandom);
                i_rec_addr  = $urandom;
                i_rec_data  = $urandom;
                @(posedge clk); #1;
            end
            chk("ready_in_load", 32'(o_rec_ready), 32'd1);
            send(sess_q[i]);
        end
        chk("ready_after_last", 32'(o_rec_ready), 32'd0);
        if (m_code == 2'b00) begin
            while (!o_core_rst_n && low < 20) begin
                @(posedge clk); #1;
                low++;
            end
            chk("release_cycles", 32'(low), 32'(REL));
            chk("run_done", 32'(o_done), 32'd1);
            chk("run_setup", 32'(o_setup), 32'd0);
            chk("run_busy", 32'(o_busy), 32'd0);
            chk("run_err", 32'(o_err), 32'd0);
        end else begin
            chk("err_flag", 32'(o_err), 32'd1);
            chk("err_core_rst_n", 32'(o_core_rst_n), 32'd0);
            chk("err_setup", 32'(o_setup), 32'd1);
            repeat (2) @(posedge clk);
            #1;
            chk("err_sticky", 32'(o_err), 32'd1);
            chk("err_ready", 32'(o_rec_ready), 32'd0);
        end
        chk("err_code", 32'(o_err_code), 32'(m_code));
        chk("instr_count", 32'(o_instr_count), 32'(m_cnt));
        chk("start_pc", o_pc_instr_start_addr, m_pc);
        chk("imem_writes_n", 32'(obs_im.size()), 32'(exp_im.size()));
        for (int i = 0; i < obs_im.size() && i < exp_im.size(); i++) begin
            chk("imem_addr", obs_im[i][63:32], exp_im[i][63:32]);
            chk("imem_data", obs_im[i][31:0], exp_im[i][31:0]);
        end
        chk("reg_writes_n", 32'(obs_rg.size()), 32'(exp_rg.size()));
        for (int i = 0; i < obs_rg.size() && i < exp_rg.size(); i++) begin
            chk("reg_addr", 32'(obs_rg[i][36:32]), 32'(exp_rg[i][36:32]));
            chk("reg_data", obs_rg[i][31:0], exp_rg[i][31:0]);
        end
    endtask

    function automatic rec_t mk(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        rec_t r;
        r.typ = t; r.addr = a; r.data = d;
        return r;
    endfunction

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'b00, 32'h4, 32'h0012_7413, 1'b1, 1'b0, 2'b00, 32'h0, 16'd1};
        vt[1] = '{2'b00, 32'h6, 32'h0000_0013, 1'b0, 1'b0, 2'b01, 32'h0, 16'd0};
        vt[2] = '{2'b00, 32'(DEPTH * 4), 32'h1, 1'b0, 1'b0, 2'b01, 32'h0, 16'd0};
        vt[3] = '{2'b00, 32'(DEPTH * 4 - 4), 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00, 32'h0, 16'd1};
        vt[4] = '{2'b01, 32'h0, 32'h0000_FFFF, 1'b0, 1'b0, 2'b00, 32'h0, 16'd0};
        vt[5] = '{2'b01, 32'h4, 32'h0000_0001, 1'b0, 1'b1, 2'b00, 32'h0, 16'd0};
        vt[6] = '{2'b01, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b1, 2'b00, 32'h0, 16'd0};
        vt[7] = '{2'b10, 32'h0, 32'h8000_0007, 1'b0, 1'b0, 2'b00, 32'h8000_0004, 16'd0};
        vt[8] = '{2'b00, 32'h1, 32'h5, 1'b0, 1'b0, 2'b01, 32'h0, 16'd0};
        vt[9] = '{2'b00, 32'hFFFF_FFFC, 32'h7, 1'b0, 1'b0, 2'b01, 32'h0, 16'd0};

        // reset state, visible before any clock edge
        #3;
        chk("rst_setup", 32'(o_setup), 32'd1);
        chk("rst_core_rst_n", 32'(o_core_rst_n), 32'd0);
        chk("rst_ready", 32'(o_rec_ready), 32'd0);
        chk("rst_busy_done", {30'b0, o_busy, o_done}, 32'd0);
        chk("rst_err", {29'b0, o_err, o_err_code}, 32'd0);
        chk("rst_strobes", {30'b0, o_inst_mem_we, o_load_reg_we}, 32'd0);
        chk("rst_pc", o_pc_instr_start_addr, 32'd0);
        chk("rst_count", 32'(o_instr_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 32'(o_rec_ready), 32'd0);

        // single-record vector table
        foreach (vt[i]) begin
            start_session();
            send(mk(vt[i].typ, vt[i].addr, vt[i].data));
            chk("vec_im_we", 32'(o_inst_mem_we), 32'(vt[i].im_we));
            chk("vec_rg_we", 32'(o_load_reg_we), 32'(vt[i].rg_we));
            chk("vec_code", 32'(o_err_code), 32'(vt[i].code));
            chk("vec_pc", o_pc_instr_start_addr, vt[i].pc);
            chk("vec_count", 32'(o_instr_count), 32'(vt[i].cnt));
            if (vt[i].im_we) begin
                chk("vec_im_addr", o_inst_mem_addr, vt[i].addr);
                chk("vec_im_data", o_inst_mem_data, vt[i].data);
            end
            if (vt[i].rg_we) begin
                chk("vec_rg_addr", 32'(o_load_reg_addr), 32'(vt[i].addr[4:0]));
                chk("vec_rg_data", o_load_reg_data, vt[i].data);
            end
            if (vt[i].code == 2'b00) finish_session();
            else wait_not_busy();
        end

        // basic boot program
        sess_q = '{mk(2'b00, 32'h4, 32'h0012_7413), mk(2'b00, 32'h8, 32'h0062_01B3),
                   mk(2'b01, 32'h4, 32'h1), mk(2'b10, 32'h0, 32'h4),
                   mk(2'b11, 32'h0, 32'h0012_7413 ^ 32'h0062_01B3)};
        play_session(0);
        chk("boot_count", 32'(o_instr_count), 32'd2);
        chk("boot_pc", o_pc_instr_start_addr, 32'h4);

        // restart from RUN: core goes back into reset on the same edge
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("restart_core_rst_n", 32'(o_core_rst_n), 32'd0);
        chk("restart_done", 32'(o_done), 32'd0);
        chk("restart_setup", 32'(o_setup), 32'd1);
        chk("restart_count", 32'(o_instr_count), 32'd0);
        chk("restart_pc", o_pc_instr_start_addr, 32'd0);
        finish_session();

        // misaligned INSTR, then recovery through i_start
        sess_q = '{mk(2'b00, 32'h6, 32'h13)};
        play_session(0);
        start_session();
        chk("recover_err", 32'(o_err), 32'd0);
        chk("recover_code", 32'(o_err_code), 32'd0);
        finish_session();

        // five back-to-back INSTRs, then the same with valid gaps
        sess_q = '{mk(2'b00, 32'h0, 32'hA0), mk(2'b00, 32'h4, 32'hA1), mk(2'b00, 32'h8, 32'hA2),
                   mk(2'b00, 32'hC, 32'hA3), mk(2'b00, 32'h10, 32'hA4),
                   mk(2'b11, 32'h0, 32'hA0 ^ 32'hA1 ^ 32'hA2 ^ 32'hA3 ^ 32'hA4)};
        play_session(0);
        play_session(60);

        // checksum match and mismatch
        sess_q = '{mk(2'b00, 32'h0, 32'h1), mk(2'b00, 32'h4, 32'h2), mk(2'b00, 32'h8, 32'h4),
                   mk(2'b11, 32'h0, 32'h7)};
        play_session(0);
        chk("csum_match_done", 32'(o_done), 32'd1);
        sess_q[3].data = 32'h6;
        play_session(0);
`ifdef BOOT_CHECKSUM_EN
        chk("csum_mismatch_code", 32'(o_err_code), 32'd2);
`else
        chk("csum_ignored_done", 32'(o_done), 32'd1);
`endif

        // asynchronous reset while a write strobe is in flight
        start_session();
        send(mk(2'b00, 32'h10, 32'h55));
        chk("pre_rst_we", 32'(o_inst_mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 32'(o_inst_mem_we), 32'd0);
        chk("arst_setup", 32'(o_setup), 32'd1);
        chk("arst_core_rst_n", 32'(o_core_rst_n), 32'd0);
        chk("arst_ready_busy", {30'b0, o_rec_ready, o_busy}, 32'd0);
        chk("arst_count", 32'(o_instr_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // random sessions
        for (int s = 0; s < 40; s++) begin
            logic [31:0] x;
            int unsigned n;
            x = '0;
            n = $urandom_range(1, 10);
            sess_q.delete();
            for (int k = 0; k < n; k++) begin
                rec_t r;
                int unsigned p;
                p = $urandom_range(0, 99);
                r.data = $urandom;
                if (p < 50) begin
                    r.typ = 2'b00;
                    if ($urandom_range(0, 99) < 88)
                        r.addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                    else if ($urandom_range(0, 1) == 0)
                        r.addr = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
                    else
                        r.addr = 32'(DEPTH * 4) + ($urandom & 32'h0000_FFFC);
                    x ^= r.data;
                end else if (p < 80) begin
                    r.typ = 2'b01;
                    r.addr = {$urandom_range(0, 1) ? 27'($urandom) : 27'b0, 5'($urandom_range(0, 31))};
                end else begin
                    r.typ = 2'b10;
                    r.addr = $urandom;
                end
                sess_q.push_back(r);
            end
            sess_q.push_back(mk(2'b11, $urandom, ($urandom_range(0, 1) == 1) ? x : $urandom));
            play_session((s % 2 == 1) ? 30 : 0);
        end

        chk("strobe_timing", orphans, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
